// File: rtl/decode_pipe_reg_if.sv
// Fetch-to-decode handshake bundle: input side (fetch) and output side (decode).
interface decode_pipe_reg_if #(
  parameter int ILEN = 32,
  parameter int PCW  = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_inst;
  logic [PCW-1:0]  in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_inst;
  logic [PCW-1:0]  out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/decode_pipe_reg.sv
// IF/ID pipeline register: main + skid entry, valid/ready both sides,
// flush, pre-split RV32 fields and a saturating stall counter.
module decode_pipe_reg #(
  parameter int ILEN = 32,
  parameter int PCW  = 32,
  parameter int RAW  = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  decode_pipe_reg_if.slave bus,
  output logic [RAW-1:0]  rs1,
  output logic [RAW-1:0]  rs2,
  output logic [RAW-1:0]  rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [24:0]     imm_raw,
  output logic [CNTW-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [PCW-1:0]  pc;
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, main_nxt, skid_q, skid_nxt, in_ent;
  logic   accept, retire;

  assign in_ent        = '{inst: bus.in_inst, pc: bus.in_pc};
  // in_ready depends only on the state register, never on out_ready
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign retire        = bus.out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_nxt  = in_ent;
          state_nxt = ONE;
        end
        ONE: begin
          if (accept && retire) begin
            main_nxt = in_ent;
          end else if (accept) begin
            skid_nxt  = in_ent;
            state_nxt = TWO;
          end else if (retire) begin
            main_nxt  = '0;
            state_nxt = EMPTY;
          end
        end
        TWO: if (retire) begin
          main_nxt  = skid_q;
          skid_nxt  = '0;
          state_nxt = ONE;
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      if (bus.out_valid && !bus.out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.out_inst = main_q.inst;
  assign bus.out_pc   = main_q.pc;
  assign opcode       = main_q.inst[6:0];
  assign rd           = main_q.inst[11:7];
  assign funct3       = main_q.inst[14:12];
  assign rs1          = main_q.inst[19:15];
  assign rs2          = main_q.inst[24:20];
  assign funct7       = main_q.inst[31:25];
  assign imm_raw      = main_q.inst[31:7];
endmodule
